ccff_chain_loader: RTL
======================

# ccff_chain_loader

Sequencer that loads a tile's configuration chain (ccff_head → … → ccff_tail) from a word-wide bitstream stream. It accepts words over a valid/ready handshake, serialises them MSB-first onto ccff_head, and raises a clock-enable to the chain's prog_clk gate only in cycles that carry a real bit. It counts exactly CHAIN_LEN bits, checks framing against the host's last-word flag, and reports done or error. It sits between the bitstream port and the tile ccff chain: logic block, output-mux memories and FF-D mux memories in chain order.

## Interface
- CHAIN_LEN, default 22: number of configuration bits in the driven chain (≥1).
- WORD_W, default 8: bitstream word width (≥1).
- Derived NWORDS = ceil(CHAIN_LEN/WORD_W): words per load (3 at defaults).

- prog_clk  in  1  configuration clock; all state on its rising edge.
- prog_reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- cfg_valid  in  1  word available.
- cfg_data  in  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- cfg_last  in  1  marks the host's final word; qualified by cfg_valid.
- cfg_ready  out  1  loader can accept a word.
- ccff_head  out  1  serial bit to chain head.
- chain_clk_en  out  1  enable for the chain's prog_clk gate; chain captures ccff_head at the edge ending an enabled cycle.
- ccff_tail  in  1  chain tail return; XOR-accumulated into tail_parity.
- busy  out  1  load in progress (LOAD or SHIFT).
- done  out  1  last load completed cleanly; sticky.
- error  out  1  last load had a framing error; sticky.
- bit_count  out  clog2(CHAIN_LEN+1)  bits shifted so far in the current load.
- tail_parity  out  1  XOR of ccff_tail sampled in every enabled cycle of the current load.

## Operation
- States: IDLE, LOAD, SHIFT, DONE, ERR. Reset enters IDLE.
- IDLE, DONE or ERR with start=1: clear bit_count, word_idx, tail_parity, done and error, then go to LOAD.
- LOAD: cfg_ready=1. On cfg_valid&cfg_ready, capture cfg_data into sreg and cfg_last into last_q, increment word_idx, then go to SHIFT.
- SHIFT: each cycle ccff_head=sreg[WORD_W-1], chain_clk_en=1, sreg shifts left by one, bit_count increments, and tail_parity ^= ccff_tail.
  - The word ends after WORD_W bits or when bit_count reaches CHAIN_LEN, whichever comes first. Leftover LSBs of the final word are discarded.
- At word end:
  - bit_count==CHAIN_LEN and last_q=1: go to DONE.
  - bit_count==CHAIN_LEN and last_q=0: go to ERR (missing last).
  - bit_count<CHAIN_LEN and last_q=1: go to ERR (early last). Shifted bits stay in the chain; no rollback.
  - Otherwise: go to LOAD.
- DONE: done=1. ERR: error=1. Both hold until start or reset. cfg_ready=0 and chain_clk_en=0 in both.
- start while busy is ignored. cfg_valid outside LOAD is not consumed.
- Reset mid-load aborts immediately. The chain keeps whatever bits were already clocked in.

## Timing
- Reset values: cfg_ready=0, ccff_head=0, chain_clk_en=0, busy=0, done=0, error=0, bit_count=0, tail_parity=0.
- ccff_head is 0 whenever chain_clk_en=0. All outputs are registered.
- start seen at cycle S: LOAD and cfg_ready=1 from S+1.
- Word accepted at cycle T: bits appear on ccff_head in cycles T+1..T+k, where k = min(WORD_W, remaining bits). cfg_ready returns at T+k+1.
  - This gives one bubble cycle per word, with chain_clk_en=0 in LOAD cycles.
- Full load with no host stall: CHAIN_LEN + NWORDS cycles from S+1 to the DONE entry edge. At defaults that is 25 cycles, so done=1 at S+26.
- chain_clk_en is high for exactly CHAIN_LEN cycles per clean load.
- Edge cases: CHAIN_LEN < WORD_W gives a single partial word. CHAIN_LEN a multiple of WORD_W leaves no discarded bits. cfg_valid held across the bubble is accepted at T+k+1.

## Test plan
- Clean load at defaults: words 0xA5, 0x3C, 0xFC with last on word 3 → ccff_head sequence 10100101 00111100 111111, chain_clk_en high for 22 cycles, done=1 at S+26, bit_count=22, error=0.
- Host stall: cfg_valid low for 5 cycles before word 2 → cfg_ready stays high, chain_clk_en stays low while stalled, same bit sequence, done 5 cycles later.
- Early last: last asserted on word 2 → error=1 after bit 16, bit_count=16, done=0, no further chain_clk_en.
- Missing last: 3 words with cfg_last=0 → error=1 with bit_count=22; then start again and a clean load → error clears and done=1.
- Reset mid-shift at bit 11: prog_reset for 1 cycle → all outputs at reset values the next cycle, cfg_ready=0 until start.
- Tail parity: ccff_tail driven with a known 22-bit pattern 0x2AAAAA → tail_parity=1 at DONE; start ignored while busy (pulse at bit 5 has no effect).

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Loads a tile configuration chain from a word-wide bitstream, MSB-first, gating
// prog_clk to the chain only in cycles that carry a real bit.
//
// state | meaning
// IDLE  | waiting for start after reset
// LOAD  | cfg_ready high, waiting for the next bitstream word
// SHIFT | presenting one bit per cycle on ccff_head with chain_clk_en high
// DONE  | CHAIN_LEN bits shifted and host flagged the final word
// ERR   | framing mismatch between bit count and cfg_last
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 22,
  parameter int WORD_W    = 8
) (
  input  logic                             prog_clk,
  input  logic                             prog_reset,
  input  logic                             start,
  input  logic                             cfg_valid,
  input  logic [WORD_W-1:0]                cfg_data,
  input  logic                             cfg_last,
  output logic                             cfg_ready,
  output logic                             ccff_head,
  output logic                             chain_clk_en,
  input  logic                             ccff_tail,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [$clog2(CHAIN_LEN+1)-1:0]   bit_count,
  output logic                             tail_parity
);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int WI_W   = $clog2(NWORDS + 1);
  localparam int BL_W   = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              last_q, last_d;
  logic [WI_W-1:0]   word_idx_q, word_idx_d;
  logic [BL_W-1:0]   bits_left_q, bits_left_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              parity_q, parity_d;
  logic              head_q, head_d;
  logic              en_q, en_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              chain_full;
  logic              word_end;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    last_d      = last_q;
    word_idx_d  = word_idx_q;
    bits_left_d = bits_left_q;
    count_d     = count_q;
    parity_d    = parity_q;
    // bit being shifted now is the last one the chain needs
    chain_full  = (count_q == CNT_W'(CHAIN_LEN - 1));
    word_end    = (bits_left_q == BL_W'(1)) || chain_full;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          count_d    = '0;
          word_idx_d = '0;
          parity_d   = 1'b0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (cfg_valid && ready_q) begin
          sreg_d      = cfg_data;
          last_d      = cfg_last;
          word_idx_d  = word_idx_q + WI_W'(1);
          bits_left_d = BL_W'(WORD_W);
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d      = sreg_q << 1;
        count_d     = count_q + CNT_W'(1);
        parity_d    = parity_q ^ ccff_tail;
        bits_left_d = bits_left_q - BL_W'(1);
        if (word_end) begin
          if (chain_full) state_d = last_q ? DONE : ERR;
          else if (last_q) state_d = ERR;
          else state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    // outputs are decoded from next state so they come straight off flops
    ready_d = (state_d == LOAD);
    en_d    = (state_d == SHIFT);
    head_d  = (state_d == SHIFT) && sreg_d[WORD_W-1];
    busy_d  = (state_d == LOAD) || (state_d == SHIFT);
    done_d  = (state_d == DONE);
    error_d = (state_d == ERR);
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      last_q      <= 1'b0;
      word_idx_q  <= '0;
      bits_left_q <= '0;
      count_q     <= '0;
      parity_q    <= 1'b0;
      head_q      <= 1'b0;
      en_q        <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      last_q      <= last_d;
      word_idx_q  <= word_idx_d;
      bits_left_q <= bits_left_d;
      count_q     <= count_d;
      parity_q    <= parity_d;
      head_q      <= head_d;
      en_q        <= en_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign cfg_ready    = ready_q;
  assign ccff_head    = head_q;
  assign chain_clk_en = en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign bit_count    = count_q;
  assign tail_parity  = parity_q;

endmodule
